vector_bit_enum: RTL

//  Streaming set-bit enumerator. It accepts a VECTOR_WIDTH vector over a valid/ready handshake.
//  It then emits one beat per set bit, in priority order: a one-hot mask, its index and a last flag.
//  It is the sequential, parametrised successor of the single-shot first-set-bit detectors.
//  It sits between a request/status vector source and a per-bit consumer (arbiter, IRQ dispatcher).

---
 rtl/vector_detect_pkg.sv | 48 ++++
 rtl/vector_isolate_lowest.sv | 20 ++
 rtl/vector_bit_enum.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vector_detect_pkg.sv
// -----------------------------------------------------------------------------
// vector_detect_pkg
// Shared types and helpers for the set-bit enumeration blocks.
//   vbe_state_t      : enumerator control state (IDLE / SCAN)
//   bit_reverse      : reverses the low 'width' bits of a vector of up to 64 bits
//   onehot_to_index  : width-generic OR-reduction one-hot to binary encoder
// Both helpers work on a 64-bit container so any vector width up to 64 can use
// them; callers zero-extend on the way in and take the low bits on the way out.
// -----------------------------------------------------------------------------
package vector_detect_pkg;

    localparam int MAX_W     = 64;
    localparam int MAX_IDX_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } vbe_state_t;

    // Bits at or above 'width' come back as zero.
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] vec,
                                                     input int              width);
        logic [MAX_W-1:0] r;
        int               j;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                j    = width - 1 - i;
                r[i] = vec[j[MAX_IDX_W-1:0]];
            end
        end
        return r;
    endfunction

    // Each index bit is the OR of all one-hot positions whose index has that
    // bit set; an all-zero input encodes to 0.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_index(input logic [MAX_W-1:0] onehot);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (onehot[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vector_isolate_lowest.sv
// -----------------------------------------------------------------------------
// vector_isolate_lowest
// Combinational isolation of the lowest set bit: lowest = x & (~x + 1).
// Ports:
//   vec_i     [VECTOR_WIDTH-1:0]  input vector
//   lowest_o  [VECTOR_WIDTH-1:0]  one-hot of the lowest set bit of vec_i, zero if vec_i==0
// -----------------------------------------------------------------------------
module vector_isolate_lowest #(
    parameter int VECTOR_WIDTH = 16
) (
    input  logic [VECTOR_WIDTH-1:0] vec_i,
    output logic [VECTOR_WIDTH-1:0] lowest_o
);

    localparam logic [VECTOR_WIDTH-1:0] ONE = {{(VECTOR_WIDTH-1){1'b0}}, 1'b1};

    // Two's complement negation keeps only the lowest set bit in common with x.
    assign lowest_o = vec_i & (~vec_i + ONE);

endmodule

// File: rtl/vector_bit_enum.sv
// -----------------------------------------------------------------------------
// vector_bit_enum
// Streaming set-bit enumerator. A vector accepted over in_valid/in_ready is
// emitted as one output beat per set bit, in priority order (LSB-first or
// MSB-first). An all-zero vector produces a single beat flagged out_zero.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active high
//   abort       drops the enumeration in progress (ignored in IDLE)
//   in_valid    in_vec is offered
//   in_ready    block accepts a vector this cycle
//   in_vec      vector to enumerate
//   out_valid   output beat valid
//   out_ready   consumer accepts the beat
//   out_onehot  one-hot mask of the current set bit (zero for an empty vector)
//   out_index   binary index of out_onehot (zero for an empty vector)
//   out_last    final beat of this vector
//   out_zero    accepted vector was all zeros
// -----------------------------------------------------------------------------
module vector_bit_enum #(
    parameter int VECTOR_WIDTH = 16,
    parameter int MSB_FIRST    = 0,
    parameter int IDX_W        = $clog2(VECTOR_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    abort,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [VECTOR_WIDTH-1:0] in_vec,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [VECTOR_WIDTH-1:0] out_onehot,
    output logic [IDX_W-1:0]        out_index,
    output logic                    out_last,
    output logic                    out_zero
);

    import vector_detect_pkg::*;

    if (VECTOR_WIDTH < 2 || VECTOR_WIDTH > MAX_W) begin : g_bad_width
        $error("vector_bit_enum: VECTOR_WIDTH must be in 2..64");
    end

    vbe_state_t              state_q;
    logic [VECTOR_WIDTH-1:0] remaining_q;

    logic [VECTOR_WIDTH-1:0] onehot;
    logic [VECTOR_WIDTH-1:0] rest;
    logic [MAX_IDX_W-1:0]    idx_full;
    logic                    scan;
    logic                    last;
    logic                    out_fire;
    logic                    in_fire;

    // Beat selection. The MSB-first order reuses the lowest-bit isolator on
    // the mirrored vector and mirrors the result back.
    if (MSB_FIRST != 0) begin : g_msb_first
        logic [MAX_W-1:0]        rem_rev_full;
        logic [MAX_W-1:0]        oh_back_full;
        logic [VECTOR_WIDTH-1:0] rem_rev;
        logic [VECTOR_WIDTH-1:0] oh_rev;
        logic                    unused_rev_bits;

        assign rem_rev_full = bit_reverse(MAX_W'(remaining_q), VECTOR_WIDTH);
        assign rem_rev      = rem_rev_full[VECTOR_WIDTH-1:0];

        vector_isolate_lowest #(
            .VECTOR_WIDTH(VECTOR_WIDTH)
        ) u_isolate (
            .vec_i   (rem_rev),
            .lowest_o(oh_rev)
        );

        assign oh_back_full    = bit_reverse(MAX_W'(oh_rev), VECTOR_WIDTH);
        assign onehot          = oh_back_full[VECTOR_WIDTH-1:0];
        assign unused_rev_bits = ^{rem_rev_full, oh_back_full};
    end else begin : g_lsb_first
        vector_isolate_lowest #(
            .VECTOR_WIDTH(VECTOR_WIDTH)
        ) u_isolate (
            .vec_i   (remaining_q),
            .lowest_o(onehot)
        );
    end

    logic unused_idx_bits;

    assign idx_full        = onehot_to_index(MAX_W'(onehot));
    assign unused_idx_bits = ^idx_full;

    // remaining_q is zero in IDLE, so onehot/index need no extra gating there.
    // In SCAN an all-zero remaining register can only mean an empty vector:
    // the last beat of a non-empty vector always leaves SCAN or reloads.
    assign scan       = (state_q == SCAN);
    assign rest       = remaining_q & ~onehot;
    assign last       = scan & (rest == '0);

    assign out_valid  = scan;
    assign out_onehot = onehot;
    assign out_index  = idx_full[IDX_W-1:0];
    assign out_last   = last;
    assign out_zero   = scan & (remaining_q == '0);

    // Accepting on the final beat lets vectors stream with no bubble; this is
    // a deliberate combinational path from out_ready to in_ready.
    assign out_fire   = scan & out_ready;
    assign in_ready   = ~scan | (out_fire & last & ~abort);
    assign in_fire    = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else if (scan && abort) begin
            // Any beat transferred this cycle is discarded.
            state_q     <= IDLE;
            remaining_q <= '0;
        end else if (in_fire) begin
            state_q     <= SCAN;
            remaining_q <= in_vec;
        end else if (out_fire && last) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else if (out_fire) begin
            remaining_q <= rest;
        end
    end

endmodule
